// File: rtl/posit_regime_decode_pipe.sv
// Two-stage posit regime decoder: stage 1 takes magnitude and regime run, stage 2 splits fields.
// Define POSIT_SPECIAL_DETECT_EN to flag zero / NaR and force their decoded fields to 0.
module posit_regime_decode_pipe #(
    parameter int N  = 32,
    parameter int ES = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N-1:0]                      in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_sign,
    output logic signed [$clog2(N):0]         out_k,
    output logic [$clog2(N)-1:0]              out_run,
    output logic [((ES > 0) ? ES : 1)-1:0]    out_exp,
    output logic [N-2-ES:0]                   out_frac,
    output logic                              out_zero,
    output logic                              out_nar
);

    localparam int RW = $clog2(N);
    localparam int KW = RW + 1;
    localparam int EW = (ES > 0) ? ES : 1;
    localparam int FW = N - 1 - ES;

    logic          v1_q;
    logic          sign1_q;
    logic [N-2:0]  body1_q;
    logic [RW-1:0] run1_q;
    logic          zero1_q;
    logic          nar1_q;

    logic          v2_q;
    logic          sign_q;
    logic [KW-1:0] k_q;
    logic [RW-1:0] run_q;
    logic [EW-1:0] exp_q;
    logic [FW-1:0] frac_q;
    logic          zero_q;
    logic          nar_q;

    logic          adv1;
    logic          adv2;

    logic [N-2:0]  body_d;
    logic [RW-1:0] run_d;
    logic          zero_d;
    logic          nar_d;

    logic [KW-1:0] runx;
    logic [KW-1:0] shamt;
    logic [N-2:0]  rem;
    logic [KW-1:0] k_d;
    logic [RW-1:0] run2_d;
    logic [EW-1:0] exp_d;
    logic [FW-1:0] frac_d;
    logic [EW-1:0] exp_raw;
    logic          special;

    assign adv2     = !v2_q || out_ready;
    assign adv1     = !v1_q || adv2;
    assign in_ready = adv1;

    // Low N-1 bits of the two's complement equal the negated low bits.
    assign body_d = in_data[N-1] ? (-in_data[N-2:0]) : in_data[N-2:0];

    always_comb begin
        logic done;
        run_d = '0;
        done  = 1'b0;
        for (int i = N - 2; i >= 0; i--) begin
            if (!done && (body_d[i] == body_d[N-2])) begin
                run_d = run_d + RW'(1);
            end else begin
                done = 1'b1;
            end
        end
    end

`ifdef POSIT_SPECIAL_DETECT_EN
    assign zero_d = (in_data == '0);
    assign nar_d  = (in_data == {1'b1, {(N-1){1'b0}}});
`else
    assign zero_d = 1'b0;
    assign nar_d  = 1'b0;
`endif

    assign runx  = {1'b0, run1_q};
    assign shamt = runx + KW'(1);
    // A shift of N-1+1 = N clears everything, covering the no-terminator case.
    assign rem   = body1_q << shamt;

    generate
        if (ES > 0) begin : g_exp
            assign exp_raw = rem[N-2 -: EW];
        end else begin : g_noexp
            assign exp_raw = '0;
        end
    endgenerate

    assign special = zero1_q || nar1_q;

    always_comb begin
        k_d    = body1_q[N-2] ? (runx - KW'(1)) : (-runx);
        run2_d = run1_q;
        exp_d  = exp_raw;
        frac_d = rem[FW-1:0];
        if (special) begin
            k_d    = '0;
            run2_d = '0;
            exp_d  = '0;
            frac_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            sign1_q <= 1'b0;
            body1_q <= '0;
            run1_q  <= '0;
            zero1_q <= 1'b0;
            nar1_q  <= 1'b0;
        end else if (adv1) begin
            v1_q <= in_valid;
            if (in_valid) begin
                sign1_q <= in_data[N-1];
                body1_q <= body_d;
                run1_q  <= run_d;
                zero1_q <= zero_d;
                nar1_q  <= nar_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q   <= 1'b0;
            sign_q <= 1'b0;
            k_q    <= '0;
            run_q  <= '0;
            exp_q  <= '0;
            frac_q <= '0;
            zero_q <= 1'b0;
            nar_q  <= 1'b0;
        end else if (adv2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                sign_q <= sign1_q;
                k_q    <= k_d;
                run_q  <= run2_d;
                exp_q  <= exp_d;
                frac_q <= frac_d;
                zero_q <= zero1_q;
                nar_q  <= nar1_q;
            end
        end
    end

    assign out_valid = v2_q;
    assign out_sign  = sign_q;
    assign out_k     = k_q;
    assign out_run   = run_q;
    assign out_exp   = exp_q;
    assign out_frac  = frac_q;
    assign out_zero  = zero_q;
    assign out_nar   = nar_q;

endmodule

// File: tb/tb_posit_regime_decode_pipe.sv
// Scoreboard bench for posit_regime_decode_pipe (N=32, ES=2) with a behavioural posit model.
module tb_posit_regime_decode_pipe;

    localparam int N  = 32;
    localparam int ES = 2;

    typedef struct packed {
        logic        sign;
        logic [5:0]  k;
        logic [4:0]  run;
        logic [1:0]  exp;
        logic [28:0] frac;
        logic        zero;
        logic        nar;
    } res_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       in_data;
    logic               in_valid;
    logic               in_ready;
    logic               out_valid;
    logic               out_ready;
    logic               out_sign;
    logic signed [5:0]  out_k;
    logic [4:0]         out_run;
    logic [1:0]         out_exp;
    logic [28:0]        out_frac;
    logic               out_zero;
    logic               out_nar;

    int tests = 0;
    int fails = 0;
    int outs  = 0;
    res_t sb[$];

    posit_regime_decode_pipe #(.N(N), .ES(ES)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_k(out_k), .out_run(out_run),
        .out_exp(out_exp), .out_frac(out_frac),
        .out_zero(out_zero), .out_nar(out_nar)
    );

    always #5 clk = ~clk;

    // Decode straight from the posit definition using integer arithmetic.
    function automatic res_t model(logic [31:0] x);
        res_t r;
        longint unsigned mag, body, rem;
        int m, kv;
        bit lead;
        r = '0;
        r.sign = x[31];
        mag  = x[31] ? ((64'h1_0000_0000 - 64'(x)) & 64'hFFFF_FFFF) : 64'(x);
        body = mag & 64'h7FFF_FFFF;
        lead = body[30];
        m = 0;
        while (m < 31 && body[30 - m] == lead) m++;
        kv = lead ? m - 1 : -m;
        rem = (body << (m + 1)) & 64'h7FFF_FFFF;
        r.k    = 6'(kv);
        r.run  = 5'(m);
        r.exp  = 2'(rem >> 29);
        r.frac = 29'(rem & 64'h1FFF_FFFF);
`ifdef POSIT_SPECIAL_DETECT_EN
        if (x == 32'h0 || x == 32'h8000_0000) begin
            r.k = '0; r.run = '0; r.exp = '0; r.frac = '0;
            r.zero = (x == 32'h0);
            r.nar  = (x == 32'h8000_0000);
        end
`endif
        return r;
    endfunction

    function automatic res_t dut_res();
        return {out_sign, out_k, out_run, out_exp, out_frac, out_zero, out_nar};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops on each output transfer, pushes on each accept.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                outs++;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out: got %h expected none", dut_res());
                end else begin
                    chk("out_word", 64'(dut_res()), 64'(sb.pop_front()));
                end
            end
            if (in_valid && in_ready) sb.push_back(model(in_data));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(logic [31:0] w);
        bit acc;
        int n;
        in_data  = w;
        in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            n++;
        end
        if (!acc) chk("send_timeout", 64'(n), 64'(0));
    endtask

    task automatic drain();
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 1000) begin
            tick();
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'(0));
    endtask

    task automatic chk_idle(string tag);
        @(negedge clk);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
        chk({tag, "_outputs"}, 64'(dut_res()), 64'(0));
    endtask

    logic [31:0] specials [8] = '{32'h0, 32'h8000_0000, 32'h4000_0000,
                                  32'hC000_0000, 32'h0000_0001, 32'hFFFF_FFFF,
                                  32'h7FFF_FFFF, 32'h8000_0001};

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        chk_idle("reset");
        tick();
        rst = 1'b0;

        // Isolated word: visible two edges after being presented.
        send(32'h4000_0000);
        in_valid = 1'b0;
        tick();
        chk("lat_valid", 64'(out_valid), 64'(1));
        chk("lat_k", 64'(out_k), 64'(0));
        chk("lat_run", 64'(out_run), 64'(1));
        tick();

        send(32'h4800_0000);
        send(32'h7000_0000);
        send(32'h2000_0000);
        send(32'hC000_0000);
        send(32'h0000_0000);
        send(32'h8000_0000);
        drain();

        // Backpressure: two words fill the pipe, third waits.
        out_ready = 1'b0;
        send(32'h4000_0000);
        send(32'h2000_0000);
        in_data = 32'h7000_0000;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            chk("bp_out_valid", 64'(out_valid), 64'(1));
            chk("bp_hold_k", 64'(out_k), 64'(0));
            chk("bp_hold_run", 64'(out_run), 64'(1));
        end
        tick();
        out_ready = 1'b1;
        send(32'h7000_0000);
        drain();

        // Reset with two words in flight and a third presented.
        out_ready = 1'b0;
        send(32'h4800_0000);
        send(32'hC000_0000);
        in_data = 32'h7000_0000;
        in_valid = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        chk_idle("midreset");
        out_ready = 1'b1;
        repeat (6) tick();
        chk("midreset_flushed", 64'(out_valid), 64'(0));

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 800; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 3) == 0)
                in_data = specials[$urandom_range(0, 7)];
            else
                in_data = $urandom;
            tick();
        end
        drain();
        chk("outputs_seen", 64'(outs > 100), 64'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
